// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, opcodes and counter helpers for the gshare predictor / rollback arbiter
package bp_pkg;

    localparam int GHR_BITS = 8;
    localparam int ROB_W    = 5;
    localparam int FL_W     = 5;
    localparam int LSQ_W    = 3;

    localparam logic [5:0] OP_JSR_GRP = 6'h1A;
    localparam logic [5:0] OP_BR      = 6'h30;
    localparam logic [5:0] OP_BSR     = 6'h34;
    localparam logic [5:0] OP_BLBC    = 6'h38;
    localparam logic [5:0] OP_BEQ     = 6'h39;
    localparam logic [5:0] OP_BLT     = 6'h3A;
    localparam logic [5:0] OP_BLE     = 6'h3B;
    localparam logic [5:0] OP_BLBS    = 6'h3C;
    localparam logic [5:0] OP_BNE     = 6'h3D;
    localparam logic [5:0] OP_BGE     = 6'h3E;
    localparam logic [5:0] OP_BGT     = 6'h3F;

    localparam logic [1:0] PHT_RESET = 2'b01;

    typedef struct packed {
        logic                done;
        logic                is_cond;
        logic                taken;
        logic [63:0]         pc;
        logic [63:0]         target_pc;
        logic [63:0]         pred_target;
        logic [GHR_BITS-1:0] ghr_snap;
        logic [ROB_W-1:0]    rob_idx;
        logic [FL_W-1:0]     fl_idx;
        logic [LSQ_W-1:0]    sq_idx;
        logic [LSQ_W-1:0]    lq_idx;
    } BR_RES_t;

    typedef struct packed {
        logic             violate;
        logic [63:0]      pc;
        logic [ROB_W-1:0] rob_idx;
        logic [FL_W-1:0]  fl_idx;
        logic [LSQ_W-1:0] sq_idx;
        logic [LSQ_W-1:0] lq_idx;
    } LDV_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    function automatic logic is_cond_op(input logic [5:0] op);
        return op inside {OP_BLBC, OP_BEQ, OP_BLT, OP_BLE, OP_BLBS, OP_BNE, OP_BGE, OP_BGT};
    endfunction

    function automatic logic is_uncond_op(input logic [5:0] op);
        return op inside {OP_BR, OP_BSR, OP_JSR_GRP};
    endfunction

endpackage

// File: rtl/rb_age_arb.sv
// rtl/rb_age_arb.sv - oldest-requester select across rollback channels
// Ties keep the lower channel, so branch channels must occupy the low indices.
module rb_age_arb #(
    parameter int N  = 4,
    parameter int AW = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         i_req,
    input  logic [N-1:0][AW-1:0] i_age,
    output logic                 o_any,
    output logic [N-1:0]         o_grant,
    output logic [AW-1:0]        o_age,
    output logic [IW-1:0]        o_sel
);

    always_comb begin
        o_any   = 1'b0;
        o_age   = '0;
        o_sel   = '0;
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i] && (!o_any || (i_age[i] > o_age))) begin
                o_any = 1'b1;
                o_age = i_age[i];
                o_sel = IW'(i);
            end
        end
        if (o_any)
            o_grant[o_sel] = 1'b1;
    end

endmodule

// File: rtl/bp_gshare_arb.sv
// rtl/bp_gshare_arb.sv - gshare direction predictor + tagged BTB with oldest-first rollback arbitration
// Tables and GHR live here; lookup reads registered state only, training lands on the next edge.
module bp_gshare_arb
    import bp_pkg::*;
#(
    parameter int NUM_SUPER    = 2,
    parameter int NUM_BR       = 2,
    parameter int NUM_LDV      = 2,
    parameter int PHT_IDX_BITS = 8,
    parameter int BTB_IDX_BITS = 6,
    parameter int BTB_TAG_BITS = 10
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic [NUM_SUPER-1:0]                i_f_valid,
    input  logic [NUM_SUPER-1:0][63:0]          i_f_pc,
    input  logic [NUM_SUPER-1:0][31:0]          i_f_ir,
    input  logic [ROB_W-1:0]                    i_rob_tail_idx,
    input  BR_RES_t [NUM_BR-1:0]                i_br_res,
    input  LDV_t [NUM_LDV-1:0]                  i_ldv_res,
    output logic [NUM_SUPER-1:0]                o_p_taken,
    output logic [NUM_SUPER-1:0]                o_p_valid,
    output logic [63:0]                         o_p_target,
    output logic [NUM_SUPER-1:0][GHR_BITS-1:0]  o_p_ghr_snap,
    output logic                                o_rollback_en,
    output logic [ROB_W-1:0]                    o_rb_rob_idx,
    output logic [FL_W-1:0]                     o_rb_fl_idx,
    output logic [LSQ_W-1:0]                    o_rb_sq_idx,
    output logic [LSQ_W-1:0]                    o_rb_lq_idx,
    output logic [ROB_W-1:0]                    o_rb_diff_rob
);

    localparam int NCH   = NUM_BR + NUM_LDV;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PHT_N = 1 << PHT_IDX_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;

    logic [1:0]              r_pht        [PHT_N];
    logic                    r_btb_valid  [BTB_N];
    logic [BTB_TAG_BITS-1:0] r_btb_tag    [BTB_N];
    logic [63:0]             r_btb_target [BTB_N];
    logic [GHR_BITS-1:0]     r_ghr;

    function automatic logic [PHT_IDX_BITS-1:0] pht_idx(input logic [63:0] pc, input logic [GHR_BITS-1:0] h);
        logic [PHT_IDX_BITS-1:0] ext;
        ext = PHT_IDX_BITS'(h) << (PHT_IDX_BITS - GHR_BITS);
        return pc[PHT_IDX_BITS+1:2] ^ ext;
    endfunction

    function automatic logic [BTB_IDX_BITS-1:0] btb_idx(input logic [63:0] pc);
        return pc[BTB_IDX_BITS+1:2];
    endfunction

    function automatic logic [BTB_TAG_BITS-1:0] btb_tag(input logic [63:0] pc);
        return pc[BTB_IDX_BITS+BTB_TAG_BITS+1:BTB_IDX_BITS+2];
    endfunction

    // ---------------- resolve channels and arbitration ----------------
    logic [NCH-1:0]            w_req;
    logic [NCH-1:0][ROB_W-1:0] w_age;
    logic [NUM_BR-1:0][63:0]   w_br_next;
    logic                      w_rollback;
    logic [NCH-1:0]            w_grant;
    logic [ROB_W-1:0]          w_win_age;
    logic [CW-1:0]             w_win_sel;

    always_comb begin
        w_req     = '0;
        w_age     = '0;
        w_br_next = '0;
        for (int k = 0; k < NUM_BR; k++) begin
            w_br_next[k] = i_br_res[k].taken ? i_br_res[k].target_pc : i_br_res[k].pc + 64'd4;
            w_req[k]     = i_br_res[k].done && (w_br_next[k] != i_br_res[k].pred_target);
            w_age[k]     = i_rob_tail_idx - i_br_res[k].rob_idx;
        end
        for (int j = 0; j < NUM_LDV; j++) begin
            w_req[NUM_BR+j] = i_ldv_res[j].violate;
            w_age[NUM_BR+j] = i_rob_tail_idx - i_ldv_res[j].rob_idx;
        end
    end

    rb_age_arb #(.N(NCH), .AW(ROB_W), .IW(CW)) u_rb_age_arb (
        .i_req   (w_req),
        .i_age   (w_age),
        .o_any   (w_rollback),
        .o_grant (w_grant),
        .o_age   (w_win_age),
        .o_sel   (w_win_sel)
    );

    logic [63:0]         w_win_target;
    logic                w_win_is_br;
    logic                w_win_cond;
    logic                w_win_taken;
    logic [GHR_BITS-1:0] w_win_snap;

    always_comb begin
        w_win_target  = '0;
        w_win_is_br   = 1'b0;
        w_win_cond    = 1'b0;
        w_win_taken   = 1'b0;
        w_win_snap    = '0;
        o_rb_rob_idx  = '0;
        o_rb_fl_idx   = '0;
        o_rb_sq_idx   = '0;
        o_rb_lq_idx   = '0;
        for (int k = 0; k < NUM_BR; k++) begin
            if (w_grant[k]) begin
                w_win_target = w_br_next[k];
                w_win_is_br  = 1'b1;
                w_win_cond   = i_br_res[k].is_cond;
                w_win_taken  = i_br_res[k].taken;
                w_win_snap   = i_br_res[k].ghr_snap;
                o_rb_rob_idx = i_br_res[k].rob_idx;
                o_rb_fl_idx  = i_br_res[k].fl_idx;
                o_rb_sq_idx  = i_br_res[k].sq_idx;
                o_rb_lq_idx  = i_br_res[k].lq_idx;
            end
        end
        // A violating load is refetched from its own PC.
        for (int j = 0; j < NUM_LDV; j++) begin
            if (w_grant[NUM_BR+j]) begin
                w_win_target = i_ldv_res[j].pc;
                o_rb_rob_idx = i_ldv_res[j].rob_idx;
                o_rb_fl_idx  = i_ldv_res[j].fl_idx;
                o_rb_sq_idx  = i_ldv_res[j].sq_idx;
                o_rb_lq_idx  = i_ldv_res[j].lq_idx;
            end
        end
    end

    assign o_rollback_en = w_rollback;
    assign o_rb_diff_rob = w_rollback ? w_win_age : '0;

    // ---------------- fetch-lane lookup ----------------
    logic [NUM_SUPER-1:0] w_lane_taken;
    logic [GHR_BITS-1:0]  w_fetch_ghr;
    logic [63:0]          w_pred_target;
    logic                 w_any_taken;

    always_comb begin
        logic [GHR_BITS-1:0]     w_h;
        logic                    w_stop;
        logic [5:0]              w_op;
        logic                    w_cond;
        logic                    w_uncond;
        logic                    w_hit;
        logic [BTB_IDX_BITS-1:0] w_bi;
        logic [PHT_IDX_BITS-1:0] w_pi;
        w_h           = r_ghr;
        w_stop        = 1'b0;
        w_op          = '0;
        w_cond        = 1'b0;
        w_uncond      = 1'b0;
        w_hit         = 1'b0;
        w_bi          = '0;
        w_pi          = '0;
        w_lane_taken  = '0;
        o_p_valid     = '0;
        o_p_ghr_snap  = '0;
        w_pred_target = '0;
        w_any_taken   = 1'b0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            o_p_ghr_snap[i] = w_h;
            o_p_valid[i]    = i_f_valid[i] && !w_rollback && !w_stop;
            w_op            = i_f_ir[i][31:26];
            w_cond          = o_p_valid[i] && is_cond_op(w_op);
            w_uncond        = o_p_valid[i] && is_uncond_op(w_op);
            w_bi            = btb_idx(i_f_pc[i]);
            w_pi            = pht_idx(i_f_pc[i], w_h);
            w_hit           = r_btb_valid[w_bi] && (r_btb_tag[w_bi] == btb_tag(i_f_pc[i]));
            w_lane_taken[i] = (w_uncond || (w_cond && r_pht[w_pi][1])) && w_hit;
            if (w_cond)
                w_h = {w_h[GHR_BITS-2:0], w_lane_taken[i]};
            if (w_lane_taken[i]) begin
                w_pred_target = r_btb_target[w_bi];
                w_any_taken   = 1'b1;
                w_stop        = 1'b1;
            end
        end
        w_fetch_ghr = w_h;
    end

    assign o_p_taken  = w_rollback ? NUM_SUPER'(1) : w_lane_taken;
    assign o_p_target = w_rollback  ? w_win_target :
                        w_any_taken ? w_pred_target : i_f_pc[NUM_SUPER-1] + 64'd4;

    logic [GHR_BITS-1:0] w_ghr_next;

    always_comb begin
        w_ghr_next = w_fetch_ghr;
        if (w_rollback) begin
            if (!w_win_is_br)
                w_ghr_next = r_ghr;
            else if (w_win_cond)
                w_ghr_next = {w_win_snap[GHR_BITS-2:0], w_win_taken};
            else
                w_ghr_next = w_win_snap;
        end
    end

    // ---------------- training ----------------
    logic [NUM_BR-1:0]                   w_elig;
    logic [NUM_BR-1:0][PHT_IDX_BITS-1:0] w_tr_pidx;
    logic [NUM_BR-1:0][BTB_IDX_BITS-1:0] w_tr_bidx;
    logic [NUM_BR-1:0][1:0]              w_tr_ctr;
    logic [NUM_BR-1:0]                   w_pht_we;
    logic [NUM_BR-1:0]                   w_btb_we;

    always_comb begin
        w_elig    = '0;
        w_tr_pidx = '0;
        w_tr_bidx = '0;
        w_tr_ctr  = '0;
        for (int k = 0; k < NUM_BR; k++) begin
            w_elig[k]    = i_br_res[k].done && (!w_rollback || (w_age[k] >= w_win_age));
            w_tr_pidx[k] = pht_idx(i_br_res[k].pc, i_br_res[k].ghr_snap);
            w_tr_bidx[k] = btb_idx(i_br_res[k].pc);
            w_tr_ctr[k]  = ctr_update(r_pht[w_tr_pidx[k]], i_br_res[k].taken);
        end
    end

    // Same-entry collisions: only the oldest channel (lowest index on equal age) writes.
    always_comb begin
        w_pht_we = '0;
        w_btb_we = '0;
        for (int k = 0; k < NUM_BR; k++) begin
            w_pht_we[k] = w_elig[k] && i_br_res[k].is_cond;
            w_btb_we[k] = w_elig[k] && i_br_res[k].taken;
            for (int j = 0; j < NUM_BR; j++) begin
                if (j != k && w_elig[j] &&
                    ((w_age[j] > w_age[k]) || ((w_age[j] == w_age[k]) && (j < k)))) begin
                    if (i_br_res[j].is_cond && (w_tr_pidx[j] == w_tr_pidx[k]))
                        w_pht_we[k] = 1'b0;
                    if (i_br_res[j].taken && (w_tr_bidx[j] == w_tr_bidx[k]))
                        w_btb_we[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ghr <= '0;
            for (int p = 0; p < PHT_N; p++)
                r_pht[p] <= PHT_RESET;
            for (int b = 0; b < BTB_N; b++) begin
                r_btb_valid[b]  <= 1'b0;
                r_btb_tag[b]    <= '0;
                r_btb_target[b] <= '0;
            end
        end else begin
            r_ghr <= w_ghr_next;
            for (int k = 0; k < NUM_BR; k++) begin
                if (w_pht_we[k])
                    r_pht[w_tr_pidx[k]] <= w_tr_ctr[k];
                if (w_btb_we[k]) begin
                    r_btb_valid[w_tr_bidx[k]]  <= 1'b1;
                    r_btb_tag[w_tr_bidx[k]]    <= btb_tag(i_br_res[k].pc);
                    r_btb_target[w_tr_bidx[k]] <= i_br_res[k].target_pc;
                end
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{i_f_ir, i_f_pc, i_br_res, i_ldv_res, w_win_sel};

endmodule

// File: tb/tb_bp_gshare_arb.sv
// tb/tb_bp_gshare_arb.sv - directed self-checking bench for bp_gshare_arb
module tb_bp_gshare_arb;
    import bp_pkg::*;

    localparam logic [31:0] IR_BEQ = 32'hE400_0000;
    localparam logic [31:0] IR_NOP = 32'h4000_0000;

    logic                  clk;
    logic                  rst;
    logic [1:0]            f_valid;
    logic [1:0][63:0]      f_pc;
    logic [1:0][31:0]      f_ir;
    logic [ROB_W-1:0]      tail;
    BR_RES_t [1:0]         br;
    LDV_t [1:0]            ldv;
    logic [1:0]            p_taken;
    logic [1:0]            p_valid;
    logic [63:0]           p_target;
    logic [1:0][GHR_BITS-1:0] p_snap;
    logic                  rb_en;
    logic [ROB_W-1:0]      rb_rob;
    logic [FL_W-1:0]       rb_fl;
    logic [LSQ_W-1:0]      rb_sq;
    logic [LSQ_W-1:0]      rb_lq;
    logic [ROB_W-1:0]      rb_diff;

    int checks = 0;
    int errors = 0;

    bp_gshare_arb dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_f_valid      (f_valid),
        .i_f_pc         (f_pc),
        .i_f_ir         (f_ir),
        .i_rob_tail_idx (tail),
        .i_br_res       (br),
        .i_ldv_res      (ldv),
        .o_p_taken      (p_taken),
        .o_p_valid      (p_valid),
        .o_p_target     (p_target),
        .o_p_ghr_snap   (p_snap),
        .o_rollback_en  (rb_en),
        .o_rb_rob_idx   (rb_rob),
        .o_rb_fl_idx    (rb_fl),
        .o_rb_sq_idx    (rb_sq),
        .o_rb_lq_idx    (rb_lq),
        .o_rb_diff_rob  (rb_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic BR_RES_t mk_br(input logic cond, input logic taken, input logic [63:0] pc,
                                      input logic [63:0] tgt, input logic [63:0] pred,
                                      input logic [GHR_BITS-1:0] snap, input logic [ROB_W-1:0] rob);
        BR_RES_t b;
        b             = '0;
        b.done        = 1'b1;
        b.is_cond     = cond;
        b.taken       = taken;
        b.pc          = pc;
        b.target_pc   = tgt;
        b.pred_target = pred;
        b.ghr_snap    = snap;
        b.rob_idx     = rob;
        return b;
    endfunction

    function automatic LDV_t mk_ldv(input logic [63:0] pc, input logic [ROB_W-1:0] rob,
                                    input logic [FL_W-1:0] fl, input logic [LSQ_W-1:0] sq,
                                    input logic [LSQ_W-1:0] lq);
        LDV_t l;
        l.violate = 1'b1;
        l.pc      = pc;
        l.rob_idx = rob;
        l.fl_idx  = fl;
        l.sq_idx  = sq;
        l.lq_idx  = lq;
        return l;
    endfunction

    initial begin
        rst = 1'b1; f_valid = 2'b11; f_pc[0] = 64'h200; f_pc[1] = 64'h204;
        f_ir[0] = IR_NOP; f_ir[1] = IR_NOP; tail = '0; br = '0; ldv = '0;

        @(negedge clk); #1;
        chk("rst_rollback", rb_en, 0);
        chk("rst_rb_rob", rb_rob, 0);
        chk("rst_rb_diff", rb_diff, 0);
        chk("rst_p_taken", p_taken, 0);
        chk("rst_p_valid", p_valid, 2'b11);
        chk("rst_p_target", p_target, 64'h208);

        // first training of the loop branch at 0x100, correctly predicted
        @(negedge clk); rst = 1'b0; f_valid = 2'b00;
        br[0] = mk_br(1, 1, 64'h100, 64'h80, 64'h80, 8'h00, 5'd0); #1;
        chk("train1_rollback", rb_en, 0);
        chk("train1_p_target", p_target, 64'h208);

        @(negedge clk); br = '0; f_valid = 2'b11;
        f_pc[0] = 64'h100; f_pc[1] = 64'h104; f_ir[0] = IR_BEQ; f_ir[1] = IR_BEQ; #1;
        chk("loop_p_taken", p_taken, 2'b01);
        chk("loop_p_valid", p_valid, 2'b01);
        chk("loop_p_target", p_target, 64'h80);
        chk("loop_snap0", p_snap[0], 8'h00);

        @(negedge clk); f_valid = 2'b01;
        f_pc[0] = 64'h300; f_pc[1] = 64'h304; f_ir[0] = IR_NOP; f_ir[1] = IR_NOP;
        br[0] = mk_br(1, 1, 64'h100, 64'h80, 64'h80, 8'h00, 5'd0); #1;
        chk("ghr_one_shift", p_snap[0], 8'h01);
        chk("nop_p_taken", p_taken, 2'b00);
        chk("nop_p_target", p_target, 64'h308);
        chk("train2_rollback", rb_en, 0);

        // two mispredicts, older br[0] (age 4) beats br[1] (age 1)
        @(negedge clk); f_valid = 2'b11; f_pc[0] = 64'h100; f_ir[0] = IR_BEQ;
        f_pc[1] = 64'h104; tail = 5'd7;
        br[0] = mk_br(0, 1, 64'h504, 64'h600, 64'h508, 8'h00, 5'd3);
        br[1] = mk_br(1, 0, 64'h100, 64'h80, 64'h80, 8'h00, 5'd6); #1;
        chk("arb_rollback", rb_en, 1);
        chk("arb_rb_rob", rb_rob, 5'd3);
        chk("arb_rb_diff", rb_diff, 5'd4);
        chk("arb_p_target", p_target, 64'h600);
        chk("arb_p_valid", p_valid, 2'b00);
        chk("arb_p_taken", p_taken, 2'b01);

        // one not-taken training: 11->10 stays taken only if br[1] was ignored
        @(negedge clk); f_valid = 2'b00; tail = '0; br = '0;
        br[0] = mk_br(1, 0, 64'h100, 64'h80, 64'h104, 8'h00, 5'd0); #1;
        chk("nt_train_rollback", rb_en, 0);

        @(negedge clk); br = '0; f_valid = 2'b01; f_pc[0] = 64'h100; f_ir[0] = IR_BEQ; #1;
        chk("uncond_ghr_restore", p_snap[0], 8'h00);
        chk("young_no_train_taken", p_taken, 2'b01);
        chk("young_no_train_target", p_target, 64'h80);

        // wrapped ROB: load age 31 beats branch age 28
        @(negedge clk); f_valid = 2'b00; tail = 5'd1;
        ldv[0] = mk_ldv(64'h700, 5'd2, 5'd9, 3'd3, 3'd4);
        br[0]  = mk_br(1, 1, 64'h100, 64'h80, 64'h104, 8'h55, 5'd5); #1;
        chk("ldv_rollback", rb_en, 1);
        chk("ldv_rb_rob", rb_rob, 5'd2);
        chk("ldv_rb_fl", rb_fl, 5'd9);
        chk("ldv_rb_sq", rb_sq, 3'd3);
        chk("ldv_rb_lq", rb_lq, 3'd4);
        chk("ldv_rb_diff", rb_diff, 5'd31);
        chk("ldv_p_target", p_target, 64'h700);

        @(negedge clk); ldv = '0; br = '0; tail = '0; f_valid = 2'b01;
        f_pc[0] = 64'h300; f_ir[0] = IR_NOP; #1;
        chk("ldv_ghr_held", p_snap[0], 8'h01);
        chk("ldv_after_rollback", rb_en, 0);

        @(negedge clk); f_valid = 2'b00;
        br[0] = mk_br(1, 1, 64'h880, 64'h900, 64'h884, 8'hA5, 5'd0); #1;
        chk("snap_rollback", rb_en, 1);
        chk("snap_p_target", p_target, 64'h900);
        chk("snap_rb_diff", rb_diff, 5'd0);

        @(negedge clk); br = '0; f_valid = 2'b11;
        f_pc[0] = 64'h1000; f_ir[0] = IR_BEQ; f_pc[1] = 64'h1004; f_ir[1] = IR_NOP; #1;
        chk("snap_repair_ghr", p_snap[0], 8'h4B);
        chk("lane1_snap", p_snap[1], 8'h96);
        chk("btb_miss_taken", p_taken, 2'b00);
        chk("btb_miss_valid", p_valid, 2'b11);
        chk("btb_miss_target", p_target, 64'h1008);

        // asynchronous reset with a pending mispredict
        @(negedge clk); rst = 1'b1; f_valid = 2'b01; f_pc[0] = 64'h100; f_ir[0] = IR_BEQ;
        br[0] = mk_br(1, 1, 64'h880, 64'h900, 64'h884, 8'h00, 5'd0); #1;
        chk("rst_mid_rollback", rb_en, 1);
        chk("rst_mid_p_valid", p_valid, 2'b00);
        chk("rst_mid_ghr", p_snap[0], 8'h00);
        chk("rst_mid_target", p_target, 64'h900);
        #1 br = '0; #1;
        chk("rst_mid_no_rollback", rb_en, 0);
        chk("rst_mid_p_taken", p_taken, 2'b00);
        chk("rst_mid_p_valid2", p_valid, 2'b01);
        chk("rst_mid_target2", p_target, 64'h1008);

        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_p_taken", p_taken, 2'b00);
        chk("post_rst_snap", p_snap[0], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
